pred_update_ctrl: RTL
=====================

Name: pred_update_ctrl

Overview:
Sequences all writes into the branch/jump predictor. It buffers update requests retired by the execute stage in a small FIFO and issues at most one update per cycle onto the predictor's update ports. On a flush or recovery request it runs an invalidation sweep over every predictor entry, and blocks predictions while the sweep is in progress. It sits between the execute/writeback stage and the predictor, and drives the predictor's fetch-address mux during sweeps.

Parameters:
DEPTH, 2, update FIFO entries (power of 2, ≥2)
ENTRIES, 16, predictor entries walked by a sweep (power of 2)
IDX_LSB, 1, bit position of the entry index within the 31-bit fetch address

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  asynchronous active-low reset
s_req_valid_i  in  1  update request valid
s_req_ready_o  out  1  request accepted when valid&ready at rising edge
s_req_btb_i  in  1  request updates BTB
s_req_branch_i  in  1  request is a conditional-branch update
s_req_jump_i  in  1  request is a jump update
s_req_taken_i  in  1  branch condition fulfilled
s_req_rvc_i  in  1  executed instruction is RVC
s_req_offset_i  in  20  target offset (halfwords)
s_req_base_i  in  32  instruction address
s_hold_i  in  1  pipeline freeze; no update issued while high
s_flush_i  in  1  start (or restart) an invalidation sweep
s_instr_rvc_o  out  1  to predictor
s_btb_update_o  out  1  to predictor
s_branch_update_o  out  1  to predictor
s_branch_taken_o  out  1  to predictor
s_jump_update_o  out  1  to predictor
s_offset_o  out  20  to predictor
s_base_add_o  out  32  to predictor
s_inv_o  out  1  invalidate entry addressed by s_inv_add_o
s_inv_add_o  out  31  fetch address used during sweep
s_pred_block_o  out  1  suppress prediction use in fetch
s_sweep_done_o  out  1  one-cycle pulse when a sweep completes
s_err_o  out  1  one-cycle pulse: malformed request dropped
s_pending_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, pointers 0, state IDLE, sweep counter 0. All outputs 0 except s_req_ready_o=1.
- States: IDLE (drain FIFO) and SWEEP.
- s_req_ready_o = (state==IDLE) & (count<DEPTH). No push is accepted when the FIFO is full, even if it is popping in the same cycle.
- Malformed request: branch&jump both set, or none of btb/branch/jump set. If accepted, it is not written; s_err_o pulses in the next cycle.
- Issue: in IDLE, when the FIFO is non-empty and ~s_hold_i, the head fields drive the update outputs combinationally. The update strobes (btb/branch/jump) are high for exactly that cycle and the head pops at the next edge.
- When not issuing, all update strobes are 0; data outputs hold the head value or 0 if empty.
- Latency: request accepted at edge k → strobe visible in cycle k..k+1 if the FIFO was empty and no hold. Throughput is 1 per cycle. Push and pop may happen on the same edge.
- s_branch_taken_o is only meaningful when s_branch_update_o=1; otherwise it is 0.
- s_flush_i in any state:
  - FIFO cleared and counter reset to 0; state → SWEEP at next edge.
  - A request presented in the same cycle is not accepted (ready already 0 by same-cycle gating).
  - A flush during SWEEP restarts the counter at 0.
- SWEEP:
  - s_inv_o=1 every cycle; s_inv_add_o = counter << IDX_LSB, other bits 0.
  - Counter increments per cycle and is not stalled by s_hold_i.
  - After index ENTRIES-1 is driven, the next edge returns to IDLE and s_sweep_done_o pulses for 1 cycle in the first IDLE cycle.
  - A sweep lasts exactly ENTRIES cycles.
- s_pred_block_o = 1 in SWEEP and in the cycle that s_sweep_done_o is high.
- No update strobe is ever asserted in SWEEP. s_inv_o and update strobes are mutually exclusive.
- Reset asserted mid-sweep or mid-drain: state returns to reset values immediately; no done pulse.
- Pointer wrap: modulo DEPTH; count distinguishes full from empty.

Test Plan:
- Single branch: btb=1, branch=1, taken=1, rvc=0, base=0x1002, offset=0x1B, FIFO empty → next cycle s_btb_update_o=s_branch_update_o=s_branch_taken_o=1, base_add=0x1002, offset=0x1B, for 1 cycle; s_pending_o back to 0.
- Back-to-back jumps with DEPTH=2 and s_hold_i=1 for 4 cycles → 2 accepted, ready=0, pending=2. Release hold → two jump strobes on consecutive cycles in order, ready=1 again.
- Malformed request: branch=1, jump=1 → no strobe, s_err_o pulses once, pending stays 0.
- Flush with 2 pending (ENTRIES=16, IDX_LSB=1):
  - s_inv_o high 16 cycles, s_inv_add_o = 0x0, 0x2, …, 0x1E.
  - s_pred_block_o high 17 cycles; s_sweep_done_o pulses once; pending=0; no update strobes.
- Flush again at sweep index 5 → counter restarts, s_inv_add_o=0x0 next cycle, sweep completes 16 cycles after the second flush.
- Reset pulled low at sweep index 7 → all outputs return to reset values asynchronously, ready=1, no done pulse after release.

Source files
------------

// File: rtl/pred_update_ctrl.sv
// Purpose: queue retired predictor updates, issue one per cycle, and run invalidation sweeps on flush.
// Latency: an accepted request strobes the predictor the cycle after its accept edge when the queue was empty and unheld.
// Backpressure: ready drops when the queue is full, during a sweep, and while flush is high.
module pred_update_ctrl #(
    parameter int DEPTH   = 2,
    parameter int ENTRIES = 16,
    parameter int IDX_LSB = 1
) (
    input  logic                     s_clk_i,
    input  logic                     s_resetn_i,
    input  logic                     s_req_valid_i,
    output logic                     s_req_ready_o,
    input  logic                     s_req_btb_i,
    input  logic                     s_req_branch_i,
    input  logic                     s_req_jump_i,
    input  logic                     s_req_taken_i,
    input  logic                     s_req_rvc_i,
    input  logic [19:0]              s_req_offset_i,
    input  logic [31:0]              s_req_base_i,
    input  logic                     s_hold_i,
    input  logic                     s_flush_i,
    output logic                     s_instr_rvc_o,
    output logic                     s_btb_update_o,
    output logic                     s_branch_update_o,
    output logic                     s_branch_taken_o,
    output logic                     s_jump_update_o,
    output logic [19:0]              s_offset_o,
    output logic [31:0]              s_base_add_o,
    output logic                     s_inv_o,
    output logic [30:0]              s_inv_add_o,
    output logic                     s_pred_block_o,
    output logic                     s_sweep_done_o,
    output logic                     s_err_o,
    output logic [$clog2(DEPTH):0]   s_pending_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic        rvc;
        logic        btb;
        logic        branch;
        logic        jump;
        logic        taken;
        logic [19:0] offset;
        logic [31:0] base;
    } upd_t;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    upd_t            mem_q [DEPTH];
    upd_t            mem_d [DEPTH];

    logic            is_idle, empty, malformed, accept, push, issue;
    upd_t            head, req;

    assign is_idle   = (state_q == IDLE);
    assign empty     = (count_q == '0);
    assign malformed = (s_req_branch_i & s_req_jump_i) |
                       ~(s_req_btb_i | s_req_branch_i | s_req_jump_i);
    assign s_req_ready_o = is_idle & (count_q < (PW+1)'(DEPTH)) & ~s_flush_i;
    assign accept    = s_req_valid_i & s_req_ready_o;
    assign push      = accept & ~malformed;
    assign issue     = is_idle & ~empty & ~s_hold_i;
    assign head      = empty ? '0 : mem_q[rd_ptr_q];

    assign req = '{rvc: s_req_rvc_i, btb: s_req_btb_i, branch: s_req_branch_i,
                   jump: s_req_jump_i, taken: s_req_taken_i,
                   offset: s_req_offset_i, base: s_req_base_i};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = accept & malformed;
        if (push) begin
            mem_d[wr_ptr_q] = req;
        end
        if (s_flush_i) begin
            // Flush discards queued updates; the sweep will wipe the predictor anyway.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = SWEEP;
            idx_d    = '0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(issue);
            if (state_q == SWEEP) begin
                if (idx_q == CW'(ENTRIES - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign s_instr_rvc_o     = head.rvc;
    assign s_offset_o        = head.offset;
    assign s_base_add_o      = head.base;
    assign s_btb_update_o    = issue & head.btb;
    assign s_branch_update_o = issue & head.branch;
    assign s_branch_taken_o  = issue & head.branch & head.taken;
    assign s_jump_update_o   = issue & head.jump;
    assign s_inv_o           = (state_q == SWEEP);
    assign s_inv_add_o       = 31'(idx_q) << IDX_LSB;
    assign s_pred_block_o    = (state_q == SWEEP) | done_q;
    assign s_sweep_done_o    = done_q;
    assign s_err_o           = err_q;
    assign s_pending_o       = count_q;
endmodule
